// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad matrix scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_t;

  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned NUM_ROWS = 4;

  // Column 0 driven low out of reset.
  localparam logic [NUM_COLS-1:0] COL_RESET = 4'b1110;

  // Index of the lowest active-low row; lowest index wins on multiple hits.
  function automatic logic [1:0] first_low(input logic [NUM_ROWS-1:0] rows);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = NUM_ROWS; i > 0; i--) begin
      if (!rows[i-1]) idx = 2'(i - 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running scan divider: tick is high for one clk cycle every SCAN_DIV cycles.
module keypad_tick_gen #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned CW = $clog2(SCAN_DIV);

  logic [CW-1:0] count;

  assign tick = (count == CW'(SCAN_DIV - 1));

  // Count 0..SCAN_DIV-1 and wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  count <= '0;
    else if (tick) count <= '0;
    else           count <= count + 1'b1;
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad matrix scanner with press/release debounce and a one-cycle
// key_valid strobe. Optional auto-repeat while held: define KEYPAD_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 8,
  parameter int unsigned REPEAT_TICKS = 250
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [1:0] key_row,
  output logic [1:0] key_col,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned CNTW = $clog2(DEBOUNCE_CNT + 1);

  if (SCAN_DIV < 4 || DEBOUNCE_CNT < 2 || REPEAT_TICKS < 1) begin : g_bad_params
    $error("keypad_scanner: parameter out of range");
  end

  logic [1:0]      rst_pipe;
  logic            rst_n_int;
  logic [3:0]      sync1, sync2;
  logic            tick;
  state_t          state;
  logic [1:0]      col_idx;
  logic [1:0]      cand_row, cand_col;
  logic [CNTW-1:0] cnt;
  logic            hit, cand_low;
  logic [1:0]      hit_row;

  // Reset asserts asynchronously, releases synchronously to clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_pipe <= '0;
    else          rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n_int = rst_pipe[1];

  // Two-flop synchronizer for the asynchronous row lines.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= row_in;
      sync2 <= sync1;
    end
  end

  keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick_gen (
    .clk     (clk),
    .reset_n (rst_n_int),
    .tick    (tick)
  );

  assign hit      = ~&sync2;
  assign hit_row  = first_low(sync2);
  assign cand_low = ~sync2[cand_row];

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_TICKS + 1);
  logic [RW-1:0] rep_cnt;
`endif

  // Scan/debounce FSM; all outputs registered, rows sampled only on tick.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state     <= SCAN;
      col_out   <= COL_RESET;
      col_idx   <= '0;
      cand_row  <= '0;
      cand_col  <= '0;
      cnt       <= '0;
      key_row   <= '0;
      key_col   <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (hit) begin
              cand_row <= hit_row;
              cand_col <= col_idx;
              cnt      <= CNTW'(1);
              state    <= DEBOUNCE;
            end else begin
              col_idx <= col_idx + 1'b1;
              col_out <= {col_out[2:0], col_out[3]};
            end
          end
          DEBOUNCE: begin
            if (cand_low) begin
              if (cnt == CNTW'(DEBOUNCE_CNT - 1)) begin
                key_row   <= cand_row;
                key_col   <= cand_col;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                cnt       <= '0;
                state     <= PRESSED;
`ifdef KEYPAD_REPEAT_EN
                rep_cnt   <= '0;
`endif
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              cnt     <= '0;
              state   <= SCAN;
              col_idx <= col_idx + 1'b1;
              col_out <= {col_out[2:0], col_out[3]};
            end
          end
          PRESSED: begin
            if (!cand_low) begin
              cnt   <= CNTW'(1);
              state <= RELEASE;
            end
`ifdef KEYPAD_REPEAT_EN
            else if (rep_cnt == RW'(REPEAT_TICKS - 1)) begin
              rep_cnt   <= '0;
              key_valid <= 1'b1;
            end else begin
              rep_cnt <= rep_cnt + 1'b1;
            end
`endif
          end
          RELEASE: begin
            if (!cand_low) begin
              if (cnt == CNTW'(DEBOUNCE_CNT - 1)) begin
                key_held <= 1'b0;
                cnt      <= '0;
                state    <= SCAN;
                col_idx  <= col_idx + 1'b1;
                col_out  <= {col_out[2:0], col_out[3]};
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              cnt   <= '0;
              state <= PRESSED;
`ifdef KEYPAD_REPEAT_EN
              rep_cnt <= '0;
`endif
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives the column lines of the 4x4 membrane keypad one at a time and samples the row lines.
- Debounces presses and releases.
- Emits a 2-bit row index and 2-bit column index with a one-cycle valid strobe.
- It is the matrix-side front end: its key_row/key_col outputs feed the keypad row/col-to-hex decoder directly.

Parameters:
- SCAN_DIV, 1000, clk cycles each column is driven before its rows are sampled; minimum 4.
- DEBOUNCE_CNT, 8, consecutive consistent samples (ticks) needed to accept a press or a release; minimum 2.
- REPEAT_TICKS, 250, ticks between auto-repeat strobes; used only with KEYPAD_REPEAT_EN.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- row_in  in  4  keypad row lines, active-low (pulled up), asynchronous to clk
- col_out  out  4  column drive, active-low, exactly one bit low at all times
- key_row  out  2  row index of accepted key (0 = top)
- key_col  out  2  column index of accepted key (0 = left)
- key_valid  out  1  one-cycle pulse per accepted press
- key_held  out  1  high while the accepted key is held (press accepted, release not yet debounced)

Behaviour:
- Reset (async assert, sync deassert internally): col_out=4'b1110, key_row=0, key_col=0, key_valid=0, key_held=0, state=SCAN, all counters 0, synchronizer flops=4'b1111.
- row_in passes through a 2-flop synchronizer before any use.
- Tick: divider counts 0..SCAN_DIV-1 and asserts tick in the cycle where count==SCAN_DIV-1. Rows are sampled only on tick.
- Hit: any synced row bit low. Selected row = lowest-index low bit. Multiple simultaneous rows: lowest index wins; no ghost rejection.
- SCAN:
  - On tick with no hit: rotate col_out to the next column (3 wraps to 0).
  - On tick with a hit: latch the row and current column into candidate registers, cnt=1, go to DEBOUNCE. Column is frozen.
- DEBOUNCE, on tick:
  - Candidate row still low: cnt+1.
  - When cnt reaches DEBOUNCE_CNT: key_row/key_col take the candidate values, key_valid=1 for exactly the next clk cycle, key_held=1, go to PRESSED.
  - Candidate row high: go to SCAN and advance the column; no strobe.
- PRESSED:
  - On tick with candidate row high: cnt=1, go to RELEASE.
  - Other rows changing in the frozen column are ignored.
- RELEASE, on tick:
  - Candidate row high: cnt+1; at DEBOUNCE_CNT, key_held=0, go to SCAN, advance the column.
  - Candidate row low again (bounce): return to PRESSED with no new strobe.
- key_row/key_col are held after release until the next accepted press.
- Latency, press stable from first hit tick to key_valid: (DEBOUNCE_CNT-1)*SCAN_DIV + 1 cycles after that tick. Worst case from press to first hit tick: 4*SCAN_DIV + 2 cycles.
- Mid-operation reset forces the reset values immediately; no strobe is emitted.

Optional Feature:
- Macro KEYPAD_REPEAT_EN: auto-repeat while a key is held.
- Defined:
  - In PRESSED, a repeat counter increments each tick.
  - At REPEAT_TICKS it clears and key_valid pulses for one cycle with the same key_row/key_col.
  - The counter clears on entry to PRESSED and is frozen in RELEASE.
- Undefined: exactly one key_valid per press; no repeat counter logic exists.

Decomposition:
- Shared package keypad_pkg:
  - state enum {SCAN, DEBOUNCE, PRESSED, RELEASE}
  - NUM_COLS=4, NUM_ROWS=4
  - reset column pattern COL_RESET=4'b1110
- One sub-module keypad_tick_gen (SCAN_DIV divider, tick output).
- Synchronizer and FSM stay in keypad_scanner.

Test Plan:
- Bench uses SCAN_DIV=4, DEBOUNCE_CNT=3, REPEAT_TICKS=5.
- Reset then idle (row_in=4'hF) for 64 cycles -> col_out cycles 1110,1101,1011,0111,1110..., changing every 4 cycles; key_valid never asserts.
- Model key at row 2 / col 1 pulling row_in[2] low while col_out[1]=0, held 60 cycles -> exactly one key_valid with key_row=2, key_col=1; key_held high until 3 release ticks after the release; then scanning resumes at column 2.
- Press row 1 / col 3 with bounce (low 1 tick, high 1 tick, then stable low) -> no strobe on the bounce; a single strobe after 3 consistent ticks with key_row=1, key_col=3.
- Rows 0 and 3 pressed together in column 0 -> key_row=0, key_col=0, one strobe.
- reset_n pulsed low during DEBOUNCE -> outputs return to reset values asynchronously; no key_valid; scanning restarts at col_out=1110.
- KEYPAD_REPEAT_EN defined, key row 3 / col 2 held 40 ticks -> first strobe, then a strobe every 5 ticks with key_row=3, key_col=2; strobes stop on release.
